// File: rtl/regfile_2r1w.sv
// regfile_2r1w: parametrised 2-read/1-write register file with optional zero entry, bypass and registered read
module regfile_2r1w #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int DEPTH    = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit REG_OUT  = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic [DW-1:0] rd_data1,
  output logic [DW-1:0] rd_data2,
  output logic          rd_valid
);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic          wr_ok;
  logic [DW-1:0] dec1, dec2;

  assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_W) && !(ZERO_REG && wr_addr == '0);
  assign dec1  = (({1'b0, rd_addr1} < DEPTH_W) && !(ZERO_REG && rd_addr1 == '0)) ? mem_q[rd_addr1] : '0;
  assign dec2  = (({1'b0, rd_addr2} < DEPTH_W) && !(ZERO_REG && rd_addr2 == '0)) ? mem_q[rd_addr2] : '0;

  // next array state: only legal writes touch storage
  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[wr_addr] = wr_data;
  end

  // storage flops, cleared immediately on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  if (REG_OUT) begin : g_reg
    logic [DW-1:0] rd_data1_q, rd_data1_d, rd_data2_q, rd_data2_d;
    logic          rd_valid_q, rd_valid_d;

    // write-first read: a same-edge legal write to the read address wins over stored data
    always_comb begin
      rd_data1_d = rd_en ? ((wr_ok && wr_addr == rd_addr1) ? wr_data : dec1) : rd_data1_q;
      rd_data2_d = rd_en ? ((wr_ok && wr_addr == rd_addr2) ? wr_data : dec2) : rd_data2_q;
      rd_valid_d = rd_en;
    end

    // registered read outputs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data1_q <= '0;
        rd_data2_q <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_data1_q <= rd_data1_d;
        rd_data2_q <= rd_data2_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign rd_data1 = rd_data1_q;
    assign rd_data2 = rd_data2_q;
    assign rd_valid = rd_valid_q;
  end else begin : g_comb
    assign rd_data1 = dec1;
    assign rd_data2 = dec2;
    assign rd_valid = rd_en;
  end
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed checks of a registered/zero-reg instance and a combinational/no-zero/DEPTH=20 instance
module tb_regfile_2r1w;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [4:0]  rd_addr1 = '0;
  logic [4:0]  rd_addr2 = '0;
  logic [31:0] a_d1, a_d2, b_d1, b_d2;
  logic        a_v, b_v;
  logic [31:0] exp_b [20];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  regfile_2r1w u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(a_d1), .rd_data2(a_d2), .rd_valid(a_v)
  );

  regfile_2r1w #(.DEPTH(20), .ZERO_REG(1'b0), .REG_OUT(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(b_d1), .rd_data2(b_d2), .rd_valid(b_v)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
    if (a < 5'd20) exp_b[a] = d;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    rd_en = 1'b1; rd_addr1 = a1; rd_addr2 = a2;
    step();
  endtask

  task automatic test_reset();
    step(); step();
    n_chk++; if (a_d1 !== 32'h0 || a_v !== 1'b0) begin n_fail++; $display("FAIL reset_a: got %h/%b exp 0/0", a_d1, a_v); end
    n_chk++; if (b_v !== 1'b0) begin n_fail++; $display("FAIL reset_b_valid: got %b exp 0", b_v); end
    rst_n = 1'b1;
    step();
    wr(5'd5, 32'hDEADBEEF);
    rd(5'd5, 5'd5);
    n_chk++; if (a_d1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pre_reset_read: got %h exp deadbeef", a_d1); end
    #3 rst_n = 1'b0;
    #1;
    n_chk++; if (a_d1 !== 32'h0 || a_v !== 1'b0) begin n_fail++; $display("FAIL async_reset_a: got %h/%b exp 0/0", a_d1, a_v); end
    n_chk++; if (b_d1 !== 32'h0) begin n_fail++; $display("FAIL async_reset_b: got %h exp 0", b_d1); end
    for (int i = 0; i < 20; i++) exp_b[i] = '0;
    #2 rst_n = 1'b1;
    rd(5'd5, 5'd5);
    n_chk++; if (a_d1 !== 32'h0 || a_v !== 1'b1) begin n_fail++; $display("FAIL post_reset_a: got %h/%b exp 0/1", a_d1, a_v); end
    n_chk++; if (b_d1 !== 32'h0) begin n_fail++; $display("FAIL post_reset_b: got %h exp 0", b_d1); end
    rd_en = 1'b0;
  endtask

  task automatic test_basic();
    wr(5'd7, 32'hA5A5A5A5);
    wr(5'd31, 32'h12345678);
    rd(5'd7, 5'd31);
    n_chk++; if (a_d1 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL basic_a_d1: got %h exp a5a5a5a5", a_d1); end
    n_chk++; if (a_d2 !== 32'h12345678) begin n_fail++; $display("FAIL basic_a_d2: got %h exp 12345678", a_d2); end
    n_chk++; if (a_v !== 1'b1) begin n_fail++; $display("FAIL basic_a_valid: got %b exp 1", a_v); end
    n_chk++; if (b_d1 !== 32'hA5A5A5A5 || b_d2 !== 32'h0) begin n_fail++; $display("FAIL basic_b: got %h/%h exp a5a5a5a5/0", b_d1, b_d2); end
    n_chk++; if (b_v !== 1'b1) begin n_fail++; $display("FAIL basic_b_valid: got %b exp 1", b_v); end
    rd_en = 1'b0;
  endtask

  task automatic test_zero();
    wr(5'd0, 32'hFFFFFFFF);
    rd(5'd0, 5'd0);
    n_chk++; if (a_d1 !== 32'h0 || a_d2 !== 32'h0) begin n_fail++; $display("FAIL zero_a: got %h/%h exp 0/0", a_d1, a_d2); end
    n_chk++; if (b_d1 !== 32'hFFFFFFFF || b_d2 !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL zero_b: got %h/%h exp ffffffff/ffffffff", b_d1, b_d2); end
    rd_en = 1'b0;
  endtask

  task automatic test_bypass();
    wr(5'd9, 32'h11111111);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFEF00D;
    rd_en = 1'b1; rd_addr1 = 5'd9; rd_addr2 = 5'd9;
    #1;
    n_chk++; if (b_d1 !== 32'h11111111 || b_d2 !== 32'h11111111) begin n_fail++; $display("FAIL bypass_b_old: got %h/%h exp 11111111", b_d1, b_d2); end
    step();
    wr_en = 1'b0; exp_b[9] = 32'hCAFEF00D;
    n_chk++; if (a_d1 !== 32'hCAFEF00D || a_d2 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL bypass_a: got %h/%h exp cafef00d", a_d1, a_d2); end
    n_chk++; if (b_d1 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL bypass_b_new: got %h exp cafef00d", b_d1); end
    rd_en = 1'b0;
  endtask

  task automatic test_hold();
    wr(5'd3, 32'h33333333);
    wr(5'd4, 32'h44444444);
    rd(5'd3, 5'd4);
    n_chk++; if (a_d1 !== 32'h33333333 || a_d2 !== 32'h44444444) begin n_fail++; $display("FAIL hold_read: got %h/%h exp 33333333/44444444", a_d1, a_d2); end
    rd_en = 1'b0;
    wr(5'd3, 32'h99999999);
    n_chk++; if (a_d1 !== 32'h33333333 || a_d2 !== 32'h44444444) begin n_fail++; $display("FAIL hold_data: got %h/%h exp 33333333/44444444", a_d1, a_d2); end
    n_chk++; if (a_v !== 1'b0 || b_v !== 1'b0) begin n_fail++; $display("FAIL hold_valid: got %b/%b exp 0/0", a_v, b_v); end
    rd(5'd3, 5'd4);
    n_chk++; if (a_d1 !== 32'h99999999) begin n_fail++; $display("FAIL hold_reread: got %h exp 99999999", a_d1); end
    rd_en = 1'b0;
  endtask

  task automatic test_range();
    wr(5'd25, 32'h11);
    wr(5'd20, 32'h22);
    wr(5'd19, 32'h19191919);
    rd(5'd25, 5'd20);
    n_chk++; if (a_d1 !== 32'h11 || a_d2 !== 32'h22) begin n_fail++; $display("FAIL range_a: got %h/%h exp 11/22", a_d1, a_d2); end
    n_chk++; if (b_d1 !== 32'h0 || b_d2 !== 32'h0) begin n_fail++; $display("FAIL range_b: got %h/%h exp 0/0", b_d1, b_d2); end
    for (int i = 0; i < 20; i++) begin
      rd(5'(i), 5'(19 - i));
      n_chk++;
      if (b_d1 !== exp_b[i] || b_d2 !== exp_b[19-i]) begin
        n_fail++;
        $display("FAIL range_entry_%0d: got %h/%h exp %h/%h", i, b_d1, b_d2, exp_b[i], exp_b[19-i]);
      end
    end
    rd_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 20; i++) exp_b[i] = '0;
    test_reset();
    test_basic();
    test_zero();
    test_bypass();
    test_hold();
    test_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
